// File: rtl/crc16_serial_checker.sv
// Receive-side serial CRC-16 checker: recomputes the CRC over an MSB-first payload,
// captures the trailing 16-bit CRC field and reports a pass/fail verdict once per frame.
module crc16_serial_checker #(
    parameter int          DATA_BITS = 32,
    parameter logic [15:0] POLY      = 16'h1021,
    parameter logic [15:0] INIT      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        sof,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic [15:0] crc_calc,
    output logic [15:0] crc_rx,
    output logic        err_abort
);

    // The CRC field reuses the counter (0..15), so it needs at least 4 bits.
    localparam int CNT_W_MIN = $clog2(DATA_BITS + 1);
    localparam int CNT_W     = (CNT_W_MIN < 4) ? 4 : CNT_W_MIN;

    localparam logic [CNT_W-1:0] LAST_PAY  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(15);
    localparam logic [CNT_W-1:0] START_CNT = (DATA_BITS == 1) ? '0 : CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRCF, S_REPORT} state_t;

    localparam state_t START_STATE = (DATA_BITS == 1) ? S_CRCF : S_PAYLOAD;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [15:0]      r_crc_calc, w_calc_nxt;
    logic [15:0]      r_crc_rx, w_rx_nxt;
    logic             r_done, w_done_nxt;
    logic             r_crc_ok, w_ok_nxt;
    logic             r_err_abort, w_abort_nxt;
    logic             w_start;
    logic             w_restart;
    logic [15:0]      w_seed;
    logic [15:0]      w_rx_shift;

    function automatic logic [15:0] lfsr_step(input logic [15:0] c, input logic b);
        lfsr_step = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? POLY : 16'h0000);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_calc_nxt  = r_crc_calc;
        w_rx_nxt    = r_crc_rx;
        w_done_nxt  = 1'b0;
        w_ok_nxt    = r_crc_ok;
        w_abort_nxt = 1'b0;
        w_restart   = 1'b0;
        w_start     = bit_valid & sof;
        w_seed      = lfsr_step(INIT, bit_in);
        w_rx_shift  = {r_crc_rx[14:0], bit_in};

        case (r_state)
            S_IDLE: begin
                w_restart = w_start;
            end
            S_REPORT: begin
                w_state_nxt = S_IDLE;
                w_restart   = w_start;
            end
            S_PAYLOAD: begin
                if (bit_valid) begin
                    if (sof) begin
                        w_restart   = 1'b1;
                        w_abort_nxt = 1'b1;
                    end else begin
                        w_calc_nxt = lfsr_step(r_crc_calc, bit_in);
                        if (r_cnt == LAST_PAY) begin
                            w_state_nxt = S_CRCF;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
            end
            S_CRCF: begin
                if (bit_valid) begin
                    if (sof) begin
                        w_restart   = 1'b1;
                        w_abort_nxt = 1'b1;
                    end else begin
                        w_rx_nxt = w_rx_shift;
                        if (r_cnt == LAST_CRC) begin
                            // Verdict uses the completed field so it is valid alongside done.
                            w_state_nxt = S_REPORT;
                            w_cnt_nxt   = '0;
                            w_done_nxt  = 1'b1;
                            w_ok_nxt    = (w_rx_shift == r_crc_calc);
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_restart) begin
            w_state_nxt = START_STATE;
            w_cnt_nxt   = START_CNT;
            w_calc_nxt  = w_seed;
            w_rx_nxt    = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_crc_calc  <= INIT;
            r_crc_rx    <= 16'h0000;
            r_done      <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_crc_calc  <= w_calc_nxt;
            r_crc_rx    <= w_rx_nxt;
            r_done      <= w_done_nxt;
            r_crc_ok    <= w_ok_nxt;
            r_err_abort <= w_abort_nxt;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign crc_ok    = r_crc_ok;
    assign crc_calc  = r_crc_calc;
    assign crc_rx    = r_crc_rx;
    assign err_abort = r_err_abort;

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Directed bench for crc16_serial_checker: known CRC vectors, gaps, aborts,
// back-to-back frames and mid-frame reset.
module tb_crc16_serial_checker;

    logic        clk;
    logic        rst;
    logic        bit_in;
    logic        bit_valid;
    logic        sof;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;
    logic        err_abort;

    int n_checks = 0;
    int n_fail   = 0;

    logic f_first_abort;
    logic f_first_ok;
    logic f_early;

    crc16_serial_checker #(
        .DATA_BITS (32),
        .POLY      (16'h1021),
        .INIT      (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_calc  (crc_calc),
        .crc_rx    (crc_rx),
        .err_abort (err_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial long division of payload*x^16 by the generator.
    function automatic logic [15:0] ref_crc(input logic [31:0] p);
        logic [47:0] v;
        v = {p, 16'h0000};
        for (int i = 47; i >= 16; i--) begin
            if (v[i]) v[i-:17] = v[i-:17] ^ {1'b1, 16'h1021};
        end
        return v[15:0];
    endfunction

    task automatic send_bit(input logic b, input logic s);
        bit_in    = b;
        sof       = s;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        sof       = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Sends the first n bits of {payload, crc}, sof on the first bit.
    task automatic send_bits(input logic [31:0] p, input logic [15:0] c, input int n, input bit gaps);
        logic [47:0] fr;
        int          g;
        fr      = {p, c};
        f_early = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                g = $urandom_range(0, 5);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                    if (done || err_abort) f_early = 1'b1;
                end
            end
            send_bit(fr[47-i], (i == 0));
            if (i == 0) begin
                f_first_abort = err_abort;
                f_first_ok    = crc_ok;
            end
            if ((i > 0 && err_abort) || (done && i != 47)) f_early = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0;
        repeat (3) idle_cycle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
        n_checks++; if (crc_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b exp 0", crc_ok); end
        n_checks++; if (crc_calc !== 16'h0000) begin n_fail++; $display("FAIL reset_calc: got %h exp 0000", crc_calc); end
        n_checks++; if (crc_rx !== 16'h0000) begin n_fail++; $display("FAIL reset_rx: got %h exp 0000", crc_rx); end
        n_checks++; if (err_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b exp 0", err_abort); end
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_zero_frame();
        send_bits(32'h0000_0000, 16'h0000, 48, 1'b0);
        n_checks++; if (f_early !== 1'b0) begin n_fail++; $display("FAIL zero_early: got %b exp 0", f_early); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b exp 1", done); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_report: got %b exp 1", busy); end
        n_checks++; if (crc_calc !== 16'h0000) begin n_fail++; $display("FAIL zero_calc: got %h exp 0000", crc_calc); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL zero_ok: got %b exp 1", crc_ok); end
        idle_cycle();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse: got %b exp 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_idle: got %b exp 0", busy); end
    endtask

    task automatic test_crc_values();
        logic [15:0] exp_c;
        send_bits(32'h0000_0001, 16'h1021, 48, 1'b0);
        n_checks++; if (crc_calc !== 16'h1021) begin n_fail++; $display("FAIL one_calc: got %h exp 1021", crc_calc); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL one_ok: got %b exp 1", crc_ok); end
        idle_cycle();
        send_bits(32'h0000_0001, 16'h1020, 48, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bad_done: got %b exp 1", done); end
        n_checks++; if (crc_ok !== 1'b0) begin n_fail++; $display("FAIL bad_ok: got %b exp 0", crc_ok); end
        n_checks++; if (crc_rx !== 16'h1020) begin n_fail++; $display("FAIL bad_rx: got %h exp 1020", crc_rx); end
        idle_cycle();
        send_bits(32'h0000_0002, 16'h2042, 48, 1'b0);
        n_checks++; if (crc_calc !== 16'h2042) begin n_fail++; $display("FAIL two_calc: got %h exp 2042", crc_calc); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL two_ok: got %b exp 1", crc_ok); end
        idle_cycle();
        exp_c = ref_crc(32'hDEAD_BEEF);
        send_bits(32'hDEAD_BEEF, exp_c, 48, 1'b0);
        n_checks++; if (crc_calc !== exp_c) begin n_fail++; $display("FAIL dead_calc: got %h exp %h", crc_calc, exp_c); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL dead_ok: got %b exp 1", crc_ok); end
        idle_cycle();
        exp_c = ref_crc(32'h8000_0000);
        send_bits(32'h8000_0000, exp_c, 48, 1'b0);
        n_checks++; if (crc_calc !== exp_c) begin n_fail++; $display("FAIL msb_calc: got %h exp %h", crc_calc, exp_c); end
        n_checks++; if (crc_rx !== exp_c) begin n_fail++; $display("FAIL msb_rx: got %h exp %h", crc_rx, exp_c); end
        idle_cycle();
    endtask

    task automatic test_gaps();
        send_bits(32'h0000_0001, 16'h1021, 48, 1'b1);
        n_checks++; if (f_early !== 1'b0) begin n_fail++; $display("FAIL gap_early: got %b exp 0", f_early); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b exp 1", done); end
        n_checks++; if (crc_calc !== 16'h1021) begin n_fail++; $display("FAIL gap_calc: got %h exp 1021", crc_calc); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL gap_ok: got %b exp 1", crc_ok); end
        repeat (4) idle_cycle();
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL gap_ok_hold: got %b exp 1", crc_ok); end
        n_checks++; if (crc_calc !== 16'h1021) begin n_fail++; $display("FAIL gap_calc_hold: got %h exp 1021", crc_calc); end
        n_checks++; if (crc_rx !== 16'h1021) begin n_fail++; $display("FAIL gap_rx_hold: got %h exp 1021", crc_rx); end
    endtask

    task automatic test_abort();
        send_bits(32'h0000_0001, 16'h1020, 48, 1'b0);
        idle_cycle();
        send_bits(32'hFFFF_FFFF, 16'hFFFF, 10, 1'b0);
        n_checks++; if (f_early !== 1'b0) begin n_fail++; $display("FAIL abort_pre_early: got %b exp 0", f_early); end
        send_bits(32'h0000_0001, 16'h1021, 48, 1'b0);
        n_checks++; if (f_first_abort !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b exp 1", f_first_abort); end
        n_checks++; if (f_first_ok !== 1'b0) begin n_fail++; $display("FAIL abort_ok_hold: got %b exp 0", f_first_ok); end
        n_checks++; if (f_early !== 1'b0) begin n_fail++; $display("FAIL abort_early: got %b exp 0", f_early); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b exp 1", done); end
        n_checks++; if (crc_calc !== 16'h1021) begin n_fail++; $display("FAIL abort_calc: got %h exp 1021", crc_calc); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL abort_ok: got %b exp 1", crc_ok); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        send_bits(32'h0000_0002, 16'h2042, 48, 1'b0);
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_a_ok: got %b exp 1", crc_ok); end
        send_bits(32'h0000_0001, 16'h1020, 48, 1'b0);
        n_checks++; if (f_first_abort !== 1'b0) begin n_fail++; $display("FAIL b2b_b_abort: got %b exp 0", f_first_abort); end
        n_checks++; if (f_early !== 1'b0) begin n_fail++; $display("FAIL b2b_b_early: got %b exp 0", f_early); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_b_done: got %b exp 1", done); end
        n_checks++; if (crc_calc !== 16'h1021) begin n_fail++; $display("FAIL b2b_b_calc: got %h exp 1021", crc_calc); end
        n_checks++; if (crc_ok !== 1'b0) begin n_fail++; $display("FAIL b2b_b_ok: got %b exp 0", crc_ok); end
        send_bits(32'h0000_0000, 16'h0000, 48, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_c_done: got %b exp 1", done); end
        n_checks++; if (crc_calc !== 16'h0000) begin n_fail++; $display("FAIL b2b_c_calc: got %h exp 0000", crc_calc); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_c_ok: got %b exp 1", crc_ok); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        send_bits(32'h0000_0001, 16'h1021, 40, 1'b0);
        rst = 1'b1;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b exp 0", busy); end
        n_checks++; if (crc_calc !== 16'h0000) begin n_fail++; $display("FAIL rmid_calc: got %h exp 0000", crc_calc); end
        n_checks++; if (crc_rx !== 16'h0000) begin n_fail++; $display("FAIL rmid_rx: got %h exp 0000", crc_rx); end
        n_checks++; if (crc_ok !== 1'b0) begin n_fail++; $display("FAIL rmid_ok: got %b exp 0", crc_ok); end
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b exp 0", done); end
        send_bits(32'h0000_0002, 16'h2042, 48, 1'b0);
        n_checks++; if (f_early !== 1'b0) begin n_fail++; $display("FAIL rmid_next_early: got %b exp 0", f_early); end
        n_checks++; if (crc_calc !== 16'h2042) begin n_fail++; $display("FAIL rmid_next_calc: got %h exp 2042", crc_calc); end
        n_checks++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL rmid_next_ok: got %b exp 1", crc_ok); end
        idle_cycle();
    endtask

    initial begin
        f_first_abort = 1'b0;
        f_first_ok    = 1'b0;
        f_early       = 1'b0;
        test_reset();
        test_zero_frame();
        test_crc_values();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
